dpram_stream_reader: RTL and testbench
======================================

// Module: dpram_stream_reader
// PURPOSE
//   Read-side engine for the dual-port RAM: on a start command, reads len words from
//   port B beginning at base and emits them as a valid/ready stream.
//   Hides the RAM's 1-cycle read latency (addrb registered in RAM, doutb next cycle)
//   behind a 2-entry output FIFO, so it sustains full throughput under backpressure.
//   Sits between the DPRAM read port and a downstream consumer (DMA, UART TX, etc.).
// PARAMETERS
//   aw  8  RAM address width; address space 2**aw words
//   dw  8  RAM data width
// PORTS
//   clk     in   1     single clock; same clock drives RAM clkb
//   rst_n   in   1     synchronous reset, active-low
//   start   in   1     command strobe; accepted only when busy==0
//   base    in   aw    first read address, sampled with start
//   len     in   aw+1  word count, 0..2**aw, sampled with start
//   busy    out  1     transfer in progress
//   done    out  1     1-cycle pulse: transfer complete
//   addrb   out  aw    RAM port-B address
//   doutb   in   dw    RAM port-B data, valid the cycle after addrb is presented
//   m_valid out  1     output word valid
//   m_ready in   1     consumer accepts word
//   m_data  out  dw    output word
// BEHAVIOUR
//   Reset (rst_n==0 at posedge): busy=0, done=0, addrb=0, m_valid=0, m_data=0,
//     FIFO emptied, pending read dropped, remaining counters cleared.
//   FSM IDLE -> RUN -> IDLE.
//     IDLE: start && len!=0 -> RUN; addrb<=base, issue_cnt<=len, out_cnt<=len, busy<=1.
//           start && len==0 -> stay IDLE, done=1 next cycle, no RAM reads.
//     RUN : start ignored. Returns to IDLE on the edge of the final output handshake:
//           busy<=0, done<=1 (done high exactly one cycle, busy low that cycle).
//   Read issue (cycle n): when RUN && issue_cnt!=0 &&
//     (fifo_occ + pend - (m_valid&&m_ready)) < 2. Word at addrb in cycle n is the read.
//     At edge: pend<=1, issue_cnt--, addrb<=addrb+1 modulo 2**aw (wraps 2**aw-1 -> 0).
//   Capture: pend==1 in cycle n+1 -> doutb pushed into FIFO at end of n+1.
//   Output: m_valid = FIFO non-empty; m_data = FIFO head; head stable while
//     m_valid && !m_ready. Handshake pops FIFO, out_cnt--. Push+pop same cycle allowed.
//   Throughput: m_ready held high -> first m_valid 2 cycles after start, then 1 word/cycle.
//   Never more than 2 words buffered; FIFO overflow impossible by the credit rule.
//   len==2**aw reads every address once, wrapping; data order = address order.
//   Data coherence with concurrent port-A writes is the RAM's, not this block's.
//   Reset mid-transfer: abort immediately, no done pulse, outputs to reset values.
// CONFIGURATION
//   DPRAM_RD_LAST_EN defined: adds port m_last (out, 1): high with m_valid on the
//     final word of a transfer (out_cnt==1); reset 0; held stable with m_data.
//   Undefined: port m_last absent; no end-of-transfer marker on the stream.
// TESTING
//   1 RAM preloaded mem[i]=i; start base=0x10 len=4, m_ready=1 -> m_data 10,11,12,13
//     on consecutive cycles, first valid 2 cycles after start, done 1 cycle after last.
//   2 base=0xFE len=4, aw=8 -> addrb FE,FF,00,01; m_data FE,FF,00,01.
//   3 len=6, m_ready toggles 1,0,0,1,... -> no word lost/duplicated, m_data stable while
//     stalled, never >2 words buffered, output = 6 words in order.
//   4 start len=0 -> done pulse next cycle, busy stays 0, m_valid never asserts;
//     start while busy -> ignored, transfer completes unchanged.
//   5 rst_n=0 after 2 of 8 words -> next cycle busy=0, m_valid=0, addrb=0, no done;
//     new start base=0 len=2 -> words 00,01 cleanly.
//   6 DPRAM_RD_LAST_EN: len=3 -> m_last high only with third word; len=1 -> first word.

Source files
------------

// File: rtl/dpram_stream_reader.sv
// Streams len words from DPRAM port B starting at base; optional m_last under DPRAM_RD_LAST_EN.
// Latency: first m_valid 2 cycles after busy rises, then 1 word/cycle; done pulses the cycle after the last handshake.
// Backpressure: a 2-entry output FIFO with read-issue credit absorbs m_ready stalls with no bubbles or overflow.
module dpram_stream_reader #(
    parameter int aw = 8,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [aw-1:0] base,
    input  logic [aw:0]   len,
    output logic          busy,
    output logic          done,
    output logic [aw-1:0] addrb,
    input  logic [dw-1:0] doutb,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [dw-1:0] m_data
`ifdef DPRAM_RD_LAST_EN
    ,
    output logic          m_last
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] addrb_q, addrb_d;
    logic [aw:0]   issue_cnt_q, issue_cnt_d;
    logic [aw:0]   out_cnt_q, out_cnt_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic [dw-1:0] head_q, head_d;
    logic [dw-1:0] tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;

    logic          hs;
    logic          issue;
    logic [2:0]    credit;

    assign m_valid = (occ_q != 2'd0);
    assign hs      = m_valid && m_ready;
    // Words held or in flight after this cycle's pop; a new read needs room for it.
    assign credit  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, hs};
    assign issue   = (state_q == RUN) && (issue_cnt_q != '0) && (credit < 3'd2);

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign addrb   = addrb_q;
    assign m_data  = head_q;
`ifdef DPRAM_RD_LAST_EN
    assign m_last  = m_valid && (out_cnt_q == {{aw{1'b0}}, 1'b1});
`endif

    always_comb begin
        state_d     = state_q;
        addrb_d     = addrb_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;
        pend_d      = issue;
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = RUN;
                        addrb_d     = base;
                        issue_cnt_d = len;
                        out_cnt_d   = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addrb_d     = addrb_q + 1'b1;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                end
                if (hs) begin
                    out_cnt_d = out_cnt_q - 1'b1;
                    if (out_cnt_q == {{aw{1'b0}}, 1'b1}) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // RAM data returns one cycle after the read was issued.
        case ({pend_q, hs})
            2'b10: begin
                if (occ_q == 2'd0) head_d = doutb;
                else               tail_d = doutb;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = doutb;
                end else begin
                    head_d = tail_q;
                    tail_d = doutb;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addrb_q     <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addrb_q     <= addrb_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader: vector table of transfers plus reset-abort sequence.
module tb_dpram_stream_reader;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef DPRAM_RD_LAST_EN
    logic          m_last;
`endif

    always #5 clk = ~clk;

    dpram_stream_reader #(.aw(AW), .dw(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base    (base),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .addrb   (addrb),
        .doutb   (doutb),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef DPRAM_RD_LAST_EN
        ,
        .m_last  (m_last)
`endif
    );

    // RAM port B: registered address, data the following cycle, mem[i] = i
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) doutb <= mem[addrb];

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  len;
        logic [15:0] pat;       // m_ready in loop cycle c is pat[c % 16]
        logic        poke;      // extra start pulse while busy
        int          exp_first; // cycle of first m_valid, -1 if none
        int          exp_done;  // cycle in which done is high
        int          exp_maxbuf;
    } vec_t;

    vec_t vt [8];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle c=0 is the first cycle after the edge that samples start.
    task automatic run_xfer(input vec_t v);
        int got = 0, first = -1, done_c = -1, done_cnt = 0;
        int issued = 0, maxbuf = 0;
        logic [7:0] prev_a;
        logic [7:0] prev_d = '0;
        logic prev_stall = 1'b0;
        base  = v.base;
        len   = v.len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prev_a = addrb;
        for (int c = 0; c < 400; c++) begin
            m_ready = v.pat[c % 16];
            if (v.poke && c == 3) begin
                start = 1'b1;
                base  = 8'h00;
                len   = 9'd1;
            end else begin
                start = 1'b0;
            end
            if (c == 0) begin
                chk("busy_c0", int'(busy), int'(v.len != 0));
                if (v.len != 0) chk("addrb_base", int'(addrb), int'(v.base));
                prev_a = addrb;
            end else if (addrb != prev_a) begin
                issued++;
                prev_a = addrb;
            end
            if (issued - got > maxbuf) maxbuf = issued - got;
            if (prev_stall) chk("stall_hold", int'(m_data), int'(prev_d));
            if (m_valid && first < 0) first = c;
`ifdef DPRAM_RD_LAST_EN
            if (m_valid) chk("m_last", int'(m_last), int'(got == int'(v.len) - 1));
`endif
            if (m_valid && m_ready) begin
                chk("data", int'(m_data), (int'(v.base) + got) & 8'hff);
                got++;
            end
            if (done) begin
                done_cnt++;
                done_c = c;
                chk("busy_at_done", int'(busy), 0);
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            if (done_cnt > 0 && c >= done_c + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("words", got, int'(v.len));
        chk("done_cnt", done_cnt, 1);
        chk("done_cycle", done_c, v.exp_done);
        chk("first_valid", first, v.exp_first);
        chk("reads", issued, int'(v.len));
        chk("max_buf", maxbuf, v.exp_maxbuf);
    endtask

    initial begin
        vec_t rv;
        int dn, vn;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);

        //        base   len     pat       poke  first done maxbuf
        vt[0] = '{8'h10, 9'd4,   16'hFFFF, 1'b0, 2,    6,   2};
        vt[1] = '{8'hFE, 9'd4,   16'hFFFF, 1'b0, 2,    6,   2};
        vt[2] = '{8'h20, 9'd6,   16'h9249, 1'b1, 2,    17,  2};
        vt[3] = '{8'h05, 9'd0,   16'hFFFF, 1'b0, -1,   0,   0};
        vt[4] = '{8'h80, 9'd256, 16'hFFFF, 1'b0, 2,    258, 2};
        vt[5] = '{8'h33, 9'd1,   16'hFFFF, 1'b0, 2,    3,   1};
        vt[6] = '{8'h40, 9'd3,   16'hAAAA, 1'b0, 2,    8,   2};
        vt[7] = '{8'hFF, 9'd3,   16'hFFF0, 1'b0, 2,    7,   2};

        rst_n   = 1'b0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    int'(busy),    0);
        chk("rst_done",    int'(done),    0);
        chk("rst_addrb",   int'(addrb),   0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data",  int'(m_data),  0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_xfer(vt[i]);
            @(posedge clk); #1;
        end

        // Reset after two of eight words have been consumed.
        base    = 8'h50;
        len     = 9'd8;
        m_ready = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy",    int'(busy),    0);
        chk("abort_m_valid", int'(m_valid), 0);
        chk("abort_addrb",   int'(addrb),   0);
        chk("abort_done",    int'(done),    0);
        chk("abort_m_data",  int'(m_data),  0);
        rst_n = 1'b1;
        dn = 0;
        vn = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done) dn++;
            if (m_valid) vn++;
        end
        chk("abort_no_done",  dn, 0);
        chk("abort_no_valid", vn, 0);
        rv = '{8'h00, 9'd2, 16'hFFFF, 1'b0, 2, 4, 2};
        run_xfer(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
